// File: rtl/core_output_ctrl.sv
// core_output_ctrl
// Drain side of the NxN systolic array. Each column of the bottom edge feeds
// its own lane FIFO with its own write strobe. Results leave the array skewed
// in time. The FIFOs absorb that skew, and whole rows are released only when
// every lane holds an entry. A job streams a host-programmed number of rows,
// then pulses done.
//
// Handshake: a row transfers on a rising clk edge where out_valid && out_ready.
// out_valid does not depend on out_ready. Once out_valid is raised, out_row
// holds stable until the transfer.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        begin a drain job (sampled only in IDLE)
//   num_rows     rows to emit for the job (sampled with start)
//   psumport[c]  column result for lane c
//   pvalid[c]    write strobe for lane c
//   out_ready    downstream accepts the presented row
//   out_valid    out_row holds an aligned row
//   out_row[c]   head entry of lane c (first-word-fall-through)
//   fulls[c]     lane c FIFO full
//   emptys[c]    lane c FIFO empty
//   overflow     sticky: a write hit a full lane (cleared by start)
//   busy         job is running
//   done         one-cycle pulse after the job completes
//   rows_left    rows still to emit in the current job
//   fsm_state    current FSM state (0 IDLE, 1 RUN, 2 DONE)
module core_output_ctrl #(
  parameter int N     = 8,
  parameter int OW    = 16,
  parameter int DEPTH = 8,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] num_rows,
  input  logic [OW-1:0] psumport [0:N-1],
  input  logic [0:N-1]  pvalid,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [OW-1:0] out_row [0:N-1],
  output logic [0:N-1]  fulls,
  output logic [0:N-1]  emptys,
  output logic          overflow,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] rows_left,
  output logic [1:0]    fsm_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [OW-1:0] mem    [0:N-1][0:DEPTH-1];
  logic [AW-1:0] rd_ptr [0:N-1];
  logic [AW-1:0] wr_ptr [0:N-1];
  logic [AW:0]   count  [0:N-1];
  logic [0:N-1]  push;
  logic [0:N-1]  wr_over;
  logic          pop;

  // Flags come only from the registered counts. A full lane refuses a write
  // even when it pops in the same cycle.
  always_comb begin
    for (int c = 0; c < N; c++) begin
      fulls[c]   = (count[c] == (AW+1)'(DEPTH));
      emptys[c]  = (count[c] == '0);
      out_row[c] = mem[c][rd_ptr[c]];
      push[c]    = pvalid[c] && !fulls[c];
      wr_over[c] = pvalid[c] && fulls[c];
    end
  end

  assign out_valid = (state == RUN) && (emptys == '0) && (rows_left != '0);
  assign pop       = out_valid && out_ready;
  assign busy      = (state == RUN);
  assign fsm_state = state;

  // Storage has no reset; only the pointers and counts define its contents.
  always_ff @(posedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (push[c]) mem[c][wr_ptr[c]] <= psumport[c];
    end
  end

  // All read pointers advance together, so the lanes stay row-aligned.
  always_ff @(posedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (rst) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        count[c]  <= '0;
      end else begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + AW'(1);
        if (pop)     rd_ptr[c] <= rd_ptr[c] + AW'(1);
        count[c] <= count[c] + (AW+1)'(push[c]) - (AW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rows_left <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state == DONE);
      // A start clears the flag. An overflow in the same cycle still sets it.
      overflow <= (overflow && !((state == IDLE) && start)) || (|wr_over);
      case (state)
        IDLE: begin
          if (start) begin
            rows_left <= num_rows;
            state     <= (num_rows != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (pop) begin
            rows_left <= rows_left - CW'(1);
            if (rows_left == CW'(1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_output_ctrl.sv
// tb_core_output_ctrl
// Self-checking bench for core_output_ctrl. A queue-per-lane reference model
// tracks what each lane holds, the job's remaining rows and the sticky
// overflow flag. Outputs are sampled 1 time unit after each rising edge.
module tb_core_output_ctrl;

  localparam int N     = 8;
  localparam int OW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic [CW-1:0] num_rows;
  logic [OW-1:0] psumport [0:N-1];
  logic [0:N-1]  pvalid;
  logic          out_ready;
  logic          out_valid;
  logic [OW-1:0] out_row [0:N-1];
  logic [0:N-1]  fulls;
  logic [0:N-1]  emptys;
  logic          overflow;
  logic          busy;
  logic          done;
  logic [CW-1:0] rows_left;
  logic [1:0]    fsm_state;

  core_output_ctrl #(.N(N), .OW(OW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .psumport(psumport), .pvalid(pvalid), .out_ready(out_ready),
    .out_valid(out_valid), .out_row(out_row), .fulls(fulls), .emptys(emptys),
    .overflow(overflow), .busy(busy), .done(done), .rows_left(rows_left),
    .fsm_state(fsm_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  logic [OW-1:0]   mq [0:N-1][$];   // contents of each lane
  logic [N*OW-1:0] exp_q [$];       // scoreboard of expected rows
  int m_left = 0;
  int m_mode = 0;                   // 0 idle, 1 running, 2 finishing
  bit m_done = 0;
  bit m_ovf  = 0;

  function automatic bit m_valid();
    bit v;
    v = (m_mode == 1) && (m_left != 0);
    for (int c = 0; c < N; c++) if (mq[c].size() == 0) v = 0;
    return v;
  endfunction

  function automatic logic [0:N-1] m_fulls();
    logic [0:N-1] f;
    for (int c = 0; c < N; c++) f[c] = (mq[c].size() == DEPTH);
    return f;
  endfunction

  function automatic logic [0:N-1] m_emptys();
    logic [0:N-1] e;
    for (int c = 0; c < N; c++) e[c] = (mq[c].size() == 0);
    return e;
  endfunction

  function automatic logic [N*OW-1:0] dut_row();
    logic [N*OW-1:0] r;
    for (int c = 0; c < N; c++) r[(N-1-c)*OW +: OW] = out_row[c];
    return r;
  endfunction

  function automatic logic [N*OW-1:0] model_row();
    logic [N*OW-1:0] r;
    r = '0;
    for (int c = 0; c < N; c++)
      if (mq[c].size() != 0) r[(N-1-c)*OW +: OW] = mq[c][0];
    return r;
  endfunction

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    bit pop;
    bit ovf;
    bit was_fin;
    int left0;
    pop = m_valid() && out_ready;
    @(posedge clk);
    if (rst) begin
      for (int c = 0; c < N; c++) mq[c].delete();
      m_left = 0; m_mode = 0; m_done = 0; m_ovf = 0;
    end else begin
      ovf = 0; was_fin = (m_mode == 2); left0 = m_left;
      for (int c = 0; c < N; c++) begin
        bit full0;
        full0 = (mq[c].size() == DEPTH);
        if (pvalid[c] && full0) ovf = 1;
        if (pop) void'(mq[c].pop_front());
        if (pvalid[c] && !full0) mq[c].push_back(psumport[c]);
      end
      if (pop) m_left = m_left - 1;
      case (m_mode)
        0: if (start) begin
             m_left = int'(num_rows);
             m_ovf  = 0;
             m_mode = (num_rows != 0) ? 1 : 2;
           end
        1: if (pop && left0 == 1) m_mode = 2;
        default: m_mode = 0;
      endcase
      m_done = was_fin;
      if (ovf) m_ovf = 1;
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    start = 0; num_rows = '0; out_ready = 0; pvalid = '0;
    for (int c = 0; c < N; c++) psumport[c] = '0;
  endtask

  task automatic drive_skew(input int t);
    for (int c = 0; c < N; c++) begin
      if (t >= c && t - c < 4) begin
        pvalid[c] = 1; psumport[c] = OW'(100 * c + t - c);
      end else begin
        pvalid[c] = 0;
      end
    end
  endtask

  task automatic drive_all_random();
    logic [N*OW-1:0] r;
    for (int c = 0; c < N; c++) begin
      pvalid[c] = 1;
      psumport[c] = OW'($urandom);
      r[(N-1-c)*OW +: OW] = psumport[c];
    end
    exp_q.push_back(r);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle(); rst = 1;
    tick(); tick();
    rst = 0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (emptys !== {N{1'b1}}) $display("FAIL reset_emptys got %b exp all 1", emptys); else n_pass++;
    n_checks++; if (fulls !== {N{1'b0}}) $display("FAIL reset_fulls got %b exp 0", fulls); else n_pass++;
    n_checks++; if (rows_left !== '0) $display("FAIL reset_rows_left got %0d exp 0", rows_left); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else n_pass++;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done got %b%b exp 00", busy, done); else n_pass++;
    n_checks++; if (fsm_state !== 2'd0) $display("FAIL reset_state got %0d exp 0", fsm_state); else n_pass++;
  endtask

  task automatic test_skewed_fill();
    int rows = 0, dones = 0, first_v = -1;
    drive_idle();
    start = 1; num_rows = 4; out_ready = 1;
    for (int t = 0; t < 24; t++) begin
      drive_skew(t);
      n_checks++; if (out_valid !== m_valid()) $display("FAIL skew_valid t=%0d got %b exp %b", t, out_valid, m_valid()); else n_pass++;
      if (out_valid === 1'b1 && first_v < 0) first_v = t;
      if (out_valid === 1'b1) begin
        for (int c = 0; c < N; c++) begin
          n_checks++;
          if (out_row[c] !== OW'(100 * c + rows)) $display("FAIL skew_row r=%0d lane=%0d got %0d exp %0d", rows, c, out_row[c], 100 * c + rows);
          else n_pass++;
        end
        rows++;
      end
      if (done === 1'b1) dones++;
      tick();
      start = 0;
    end
    n_checks++; if (first_v != 8) $display("FAIL skew_first_valid got cycle %0d exp 8", first_v); else n_pass++;
    n_checks++; if (rows != 4) $display("FAIL skew_rows got %0d exp 4", rows); else n_pass++;
    n_checks++; if (dones != 1) $display("FAIL skew_done_pulses got %0d exp 1", dones); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL skew_busy_end got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    int rows = 0;
    bit stalled = 0;
    logic [N*OW-1:0] held;
    drive_idle();
    start = 1; num_rows = 4;
    for (int t = 0; t < 30; t++) begin
      drive_skew(t);
      out_ready = (t % 3 == 0);
      if (stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || dut_row() !== held) $display("FAIL bp_hold t=%0d got valid=%b row=%h exp row=%h", t, out_valid, dut_row(), held);
        else n_pass++;
      end
      n_checks++; if (rows_left !== CW'(m_left)) $display("FAIL bp_rows_left t=%0d got %0d exp %0d", t, rows_left, m_left); else n_pass++;
      n_checks++; if (out_valid !== m_valid()) $display("FAIL bp_valid t=%0d got %b exp %b", t, out_valid, m_valid()); else n_pass++;
      stalled = (out_valid === 1'b1) && !out_ready;
      held = dut_row();
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (out_row[0] !== OW'(rows) || out_row[N-1] !== OW'(100 * (N-1) + rows))
          $display("FAIL bp_row r=%0d got %0d,%0d exp %0d,%0d", rows, out_row[0], out_row[N-1], rows, 100 * (N-1) + rows);
        else n_pass++;
        rows++;
      end
      tick();
      start = 0;
    end
    n_checks++; if (rows != 4) $display("FAIL bp_rows got %0d exp 4", rows); else n_pass++;
  endtask

  task automatic test_full_overflow();
    int rows = 0;
    drive_idle();
    for (int i = 0; i < 9; i++) begin
      pvalid = '0; pvalid[0] = 1; psumport[0] = OW'(i);
      tick();
      if (i == 7) begin
        n_checks++; if (fulls[0] !== 1'b1 || overflow !== 1'b0) $display("FAIL full_after8 got full=%b ovf=%b exp 1 0", fulls[0], overflow); else n_pass++;
      end
    end
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b exp 1", overflow); else n_pass++;
    n_checks++; if (fulls !== m_fulls()) $display("FAIL ovf_fulls got %b exp %b", fulls, m_fulls()); else n_pass++;
    pvalid = '0; start = 1; num_rows = 8;
    tick();
    start = 0;
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b exp 0", overflow); else n_pass++;
    out_ready = 1;
    for (int t = 0; t < 20; t++) begin
      pvalid = '0;
      if (t < 8) for (int c = 1; c < N; c++) begin pvalid[c] = 1; psumport[c] = OW'(1000 + t); end
      n_checks++; if (out_valid !== m_valid()) $display("FAIL ovf_valid t=%0d got %b exp %b", t, out_valid, m_valid()); else n_pass++;
      if (out_valid === 1'b1) begin
        n_checks++;
        if (out_row[0] !== OW'(rows) || out_row[3] !== OW'(1000 + rows)) $display("FAIL ovf_lane0 r=%0d got %0d,%0d exp %0d,%0d", rows, out_row[0], out_row[3], rows, 1000 + rows);
        else n_pass++;
        rows++;
      end
      tick();
    end
    n_checks++; if (rows != 8) $display("FAIL ovf_rows got %0d exp 8", rows); else n_pass++;
    n_checks++; if (emptys !== {N{1'b1}}) $display("FAIL ovf_drained got %b exp all 1", emptys); else n_pass++;
  endtask

  task automatic test_wrap();
    int rows = 0;
    bit seen_done = 0;
    drive_idle();
    exp_q.delete();
    start = 1; num_rows = 20; out_ready = 1;
    for (int t = 0; t < 40; t++) begin
      if (t < 20) drive_all_random(); else pvalid = '0;
      n_checks++; if (fulls !== '0) $display("FAIL wrap_full t=%0d got %b exp 0", t, fulls); else n_pass++;
      if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL wrap_extra_row t=%0d got %h exp none", t, dut_row());
        else if (dut_row() !== exp_q[0]) $display("FAIL wrap_row r=%0d got %h exp %h", rows, dut_row(), exp_q[0]);
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        rows++;
      end
      if (done === 1'b1) seen_done = 1;
      tick();
      start = 0;
    end
    n_checks++; if (rows != 20 || exp_q.size() != 0) $display("FAIL wrap_rows got %0d exp 20 (left %0d)", rows, exp_q.size()); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL wrap_overflow got %b exp 0", overflow); else n_pass++;
    n_checks++; if (!seen_done) $display("FAIL wrap_done got none exp pulse"); else n_pass++;
  endtask

  task automatic test_zero_rows();
    int rows = 0;
    bit busy_seen = 0, seen_done = 0;
    drive_idle();
    start = 1; num_rows = 0;
    tick(); start = 0;
    if (busy !== 1'b0) busy_seen = 1;
    n_checks++; if (done !== 1'b0) $display("FAIL zero_done_early got %b exp 0", done); else n_pass++;
    tick();
    if (busy !== 1'b0) busy_seen = 1;
    n_checks++; if (done !== 1'b1) $display("FAIL zero_done got %b exp 1", done); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b0 || busy_seen) $display("FAIL zero_after got done=%b busy_seen=%b exp 0 0", done, busy_seen); else n_pass++;
    start = 1; num_rows = 3;
    tick();
    start = 1; num_rows = 9;
    n_checks++; if (busy !== 1'b1 || rows_left !== CW'(3)) $display("FAIL three_start got busy=%b left=%0d exp 1 3", busy, rows_left); else n_pass++;
    tick();
    start = 0;
    n_checks++; if (rows_left !== CW'(3)) $display("FAIL ignored_start got %0d exp 3", rows_left); else n_pass++;
    exp_q.delete();
    out_ready = 1;
    for (int t = 0; t < 20 && !seen_done; t++) begin
      if (t < 3) drive_all_random(); else pvalid = '0;
      if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0 || dut_row() !== exp_q[0]) $display("FAIL three_row r=%0d got %h exp %h", rows, dut_row(), model_row());
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        rows++;
      end
      tick();
      if (done === 1'b1) seen_done = 1;
    end
    n_checks++; if (!seen_done || rows != 3) $display("FAIL three_job got done=%b rows=%0d exp 1 3", seen_done, rows); else n_pass++;
  endtask

  task automatic test_midjob_reset();
    int rows = 0;
    bit seen_done = 0;
    drive_idle();
    exp_q.delete();
    for (int t = 0; t < 4; t++) begin drive_all_random(); tick(); end
    pvalid = '0;
    n_checks++; if (emptys !== '0) $display("FAIL mid_prefill got %b exp 0", emptys); else n_pass++;
    start = 1; num_rows = 4; out_ready = 1;
    for (int t = 0; t < 20 && rows < 2; t++) begin
      if (out_valid === 1'b1) rows++;
      tick();
      start = 0;
    end
    n_checks++; if (rows != 2 || rows_left !== CW'(2)) $display("FAIL mid_two_rows got rows=%0d left=%0d exp 2 2", rows, rows_left); else n_pass++;
    rst = 1;
    tick();
    rst = 0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (emptys !== {N{1'b1}}) $display("FAIL mid_rst_emptys got %b exp all 1", emptys); else n_pass++;
    n_checks++; if (rows_left !== '0 || fsm_state !== 2'd0) $display("FAIL mid_rst_state got left=%0d st=%0d exp 0 0", rows_left, fsm_state); else n_pass++;
    exp_q.delete();
    start = 1; num_rows = 1;
    drive_all_random();
    rows = 0;
    for (int t = 0; t < 10 && !seen_done; t++) begin
      if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0 || dut_row() !== exp_q[0]) $display("FAIL mid_new_row got %h exp %h", dut_row(), model_row());
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        rows++;
      end
      tick();
      start = 0; pvalid = '0;
      if (done === 1'b1) seen_done = 1;
    end
    n_checks++; if (!seen_done || rows != 1) $display("FAIL mid_new_job got done=%b rows=%0d exp 1 1", seen_done, rows); else n_pass++;
  endtask

  task automatic test_random_traffic();
    drive_idle();
    for (int t = 0; t < 400; t++) begin
      start = 0;
      if (m_mode == 0 && $urandom_range(0, 3) == 0) begin
        start = 1; num_rows = CW'($urandom_range(0, 12));
      end
      for (int c = 0; c < N; c++) begin
        pvalid[c] = ($urandom_range(0, 9) < 6);
        psumport[c] = OW'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      n_checks++; if (out_valid !== m_valid()) $display("FAIL rnd_valid t=%0d got %b exp %b", t, out_valid, m_valid()); else n_pass++;
      if (m_valid()) begin
        n_checks++; if (dut_row() !== model_row()) $display("FAIL rnd_row t=%0d got %h exp %h", t, dut_row(), model_row()); else n_pass++;
      end
      n_checks++; if (fulls !== m_fulls() || emptys !== m_emptys()) $display("FAIL rnd_flags t=%0d got %b/%b exp %b/%b", t, fulls, emptys, m_fulls(), m_emptys()); else n_pass++;
      n_checks++; if (rows_left !== CW'(m_left)) $display("FAIL rnd_rows_left t=%0d got %0d exp %0d", t, rows_left, m_left); else n_pass++;
      n_checks++; if (overflow !== m_ovf) $display("FAIL rnd_overflow t=%0d got %b exp %b", t, overflow, m_ovf); else n_pass++;
      n_checks++; if (busy !== (m_mode == 1) || done !== m_done) $display("FAIL rnd_busy_done t=%0d got %b%b exp %b%b", t, busy, done, m_mode == 1, m_done); else n_pass++;
      tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_skewed_fill();
    test_backpressure();
    test_full_overflow();
    test_wrap();
    test_zero_rows();
    test_midjob_reset();
    test_random_traffic();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got no finish exp finish within budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/core_output_ctrl.md
Name: core_output_ctrl

Overview:
- Drain-side counterpart of the core input controller.
- Collects skewed partial-sum results leaving the bottom edge of the NxN systolic array, one lane per column, each lane with its own valid.
- Buffers each lane in a per-column FIFO and re-aligns the lanes into whole rows.
- Streams those rows out through a valid/ready handshake for a host-programmed row count, then pulses done.

Parameters:
N, 8, number of array columns / output lanes
OW, 16, partial-sum width in bits
DEPTH, 8, entries per lane FIFO (power of two)
CW, 8, width of row count and row counter

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
start  input  1  begin a drain job (sampled only in IDLE)
num_rows  input  CW  rows to emit for this job (sampled with start)
psumport  input  [OW-1:0] x N (unpacked [0:N-1])  column results from array
pvalid  input  [0:N-1]  per-lane write strobe
out_ready  input  1  downstream accepts row
out_valid  output  1  out_row holds an aligned row
out_row  output  [OW-1:0] x N  head entry of every lane
fulls  output  [0:N-1]  per-lane FIFO full
emptys  output  [0:N-1]  per-lane FIFO empty
overflow  output  1  sticky: a write hit a full lane
busy  output  1  state == RUN
done  output  1  one-cycle pulse at job completion
rows_left  output  CW  remaining rows in current job

Behaviour:
- Reset, applied at any time including mid-job:
  - Synchronous: every FIFO pointer/count is cleared, state goes to IDLE, and rows_left, overflow, done and out_valid are driven 0.
  - emptys = all 1, fulls = all 0.
  - FIFO storage contents are don't-care.
- Lane FIFO c:
  - Circular buffer with a log2(DEPTH)-bit read pointer and write pointer, plus a count of 0..DEPTH.
  - Pointers wrap DEPTH-1 -> 0.
  - full = (count == DEPTH); empty = (count == 0). Both are registered-state derived, with no combinational path from inputs.
- Write:
  - In any state, pvalid[c] && !fulls[c] stores psumport[c] at the write pointer and increments that pointer.
  - pvalid[c] && fulls[c] drops the data and sets overflow on the next edge. This holds even if the same lane pops in that cycle: a full lane never accepts a write.
- Read:
  - FIFOs are first-word-fall-through; out_row[c] = entry at read pointer of lane c.
  - out_valid = (state == RUN) && (emptys == 0) && (rows_left != 0), i.e. a row exists only when every lane is non-empty.
  - A pop occurs when out_valid && out_ready. It advances all N read pointers together and decrements rows_left.
  - Lanes never pop individually.
- Simultaneous push and pop on a non-full lane: count is unchanged, and both pointers advance.
- out_row must hold stable while out_valid && !out_ready.
- FSM, states IDLE, RUN, DONE:
  - IDLE: start -> load rows_left = num_rows and clear overflow. Go to RUN if num_rows != 0, else go to DONE.
  - RUN: a pop with rows_left == 1 -> DONE. start is ignored in RUN.
  - DONE: done = 1 for exactly one cycle, then go to IDLE. start is ignored in DONE.
- Data left in the FIFOs after a job is retained for the next job; start does not flush.
- busy = 1 only in RUN.
- Throughput: one row per cycle when all lanes are non-empty and out_ready is held high.
- Latency: a write at edge k is visible on out_row in the cycle after edge k, with no extra pipeline stage.

Test Plan:
1. Skewed fill, basic drain:
   - Stimulus: reset; start with num_rows=4. Lane c writes values 100*c+r for r=0..3, starting at cycle c (diagonal skew); out_ready=1.
   - Required: exactly 4 rows, row r = {r, 100+r, ..., 700+r}; first out_valid only after lane 7's first write; done pulses once; busy then drops.
2. Backpressure:
   - Stimulus: same data as scenario 1, with out_ready toggled 1,0,0,1...
   - Required: out_row stable during stalls; no row lost or duplicated; rows_left goes 4, 3, 2, 1, 0 only on accepted cycles.
3. Full and overflow:
   - Stimulus: write 9 entries into lane 0 only, with no job running.
   - Required: fulls[0]=1 after the 8th write; the 9th write is dropped and overflow=1.
   - Follow-up: a later start clears overflow, and lane 0 still holds values 0..7 in order.
4. Pointer wrap:
   - Stimulus: num_rows=20, DEPTH=8, all lanes written every cycle, out_ready=1.
   - Required: 20 correct rows in order across multiple wraps; count never exceeds 8; no overflow.
5. Zero rows, ignored start:
   - Stimulus: start with num_rows=0.
   - Required: done pulses 2 cycles after start, and busy is never 1.
   - Also: a second start asserted during RUN of a 3-row job leaves rows_left unchanged.
6. Mid-job reset:
   - Stimulus: assert rst after 2 of 4 rows have been emitted.
   - Required: next cycle out_valid=0, emptys all 1, rows_left=0, state IDLE; a new 1-row job then completes normally.
